dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9: byte-address width; memory capacity 2^ADDR_W bytes.
REQ-002 Parameter DATA_W, default 32: data width; legal values 32 and 64 only.
REQ-003 Parameter WAIT_CYCLES, default 0: wait states inserted before each memory access; legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RISC-V funct3 of the load/store.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  DATA_W  store data, LSB-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_rdata  output  DATA_W  load result, extended to DATA_W.
REQ-015 rsp_err  output  1  misaligned or illegal request.

Function
REQ-016 Storage: DATA_W/8 byte lanes; word index = req_addr[ADDR_W-1:log2(DATA_W/8)]; lane offset = remaining low bits; contents not reset.
REQ-017 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-018 Acceptance: req_valid && req_ready at a rising edge; request fields are latched at that edge and inputs are ignored afterwards until return to IDLE.
REQ-019 Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; if DATA_W=64, additionally load 011 LD, 110 LWU and store 011 SD; all others illegal.
REQ-020 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; doubleword requires addr[2:0]=0; byte is always aligned.
REQ-021 Illegal or misaligned request: IDLE -> RESP at acceptance edge; rsp_err=1; rsp_rdata=0; no memory write; no wait states.
REQ-022 Legal request, WAIT_CYCLES=0: access is performed at acceptance edge; IDLE -> RESP.
REQ-023 Legal request, WAIT_CYCLES>0: IDLE -> WAIT with counter loaded to WAIT_CYCLES-1; counter decrements each cycle; at edge where counter=0, access is performed and WAIT -> RESP.
REQ-024 Latency: rsp_valid asserts WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-025 Store: writes only the addressed lanes (1, 2, 4 or 8 bytes) with req_wdata low bytes shifted to lane offset; other lanes unchanged; rsp_rdata=0, rsp_err=0.
REQ-026 Load: selects the addressed bytes; sign-extends for LB/LH/LW, zero-extends for LBU/LHU/LWU; LW on DATA_W=32 and LD are unextended; result registered into rsp_rdata at access edge.
REQ-027 RESP: rsp_valid, rsp_rdata and rsp_err hold stable until rsp_valid && rsp_ready; at that edge RESP -> IDLE, rsp_valid=0.
REQ-028 Back-to-back: the next acceptance is possible at the earliest one cycle after the response handshake; one outstanding transaction maximum.
REQ-029 Read-after-write: a load accepted after a store's response returns the stored data.
REQ-030 req_valid while not in IDLE has no effect.

Reset
REQ-031 rst_n low asynchronously forces IDLE, counter=0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-032 Reset asserted during WAIT abandons the transaction; an uncommitted store does not modify memory.
REQ-033 Memory array is not cleared by reset.

Verification
REQ-034 WAIT_CYCLES=0: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_valid 1 cycle after accept, rdata 0xDEADBEEF, err 0.
REQ-035 After REQ-034: LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
REQ-036 SB 0x011 data 0x55 over 0xDEADBEEF, then LW 0x010 -> 0xDEAD55EF.
REQ-037 LW 0x012 -> err 1, rdata 0, rsp after 1 cycle; subsequent LW 0x010 shows memory unchanged; funct3 111 -> err 1.
REQ-038 WAIT_CYCLES=3: rsp_valid at 4th edge after accept; rsp_ready held low 5 cycles -> outputs stable; req_valid ignored until after handshake.
REQ-039 WAIT_CYCLES=3: SW 0x020 data 0x12345678; rst_n pulsed low in WAIT -> IDLE, outputs 0; LW 0x020 returns prior contents.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between a load/store unit and the data memory controller.
// Latency: none, plain wires.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-lane data memory with RISC-V load/store sizing, extension and misalignment detection.
// Latency: response valid WAIT_CYCLES+1 cycles after acceptance; errors respond after 1 cycle.
// Backpressure: one transaction outstanding; req_ready only in IDLE, response held until rsp_ready.
module dmem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input logic         clk,
    input logic         rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int WORDS = 1 << IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [WORDS];

    logic              idle;
    logic              accept;
    logic              legal;
    logic              do_access;
    logic              a_we;
    logic [2:0]        a_f3;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] load_res;
    logic [DATA_W-1:0] wd_sh;
    logic [NB-1:0]     size_be;
    logic [NB-1:0]     be;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] w32;

    assign idle          = (state == S_IDLE);
    assign accept        = idle && bus.req_valid;
    assign bus.req_ready = idle;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // The zero-wait access happens on the accepting edge, so it works off the live inputs.
    assign a_we    = idle ? bus.req_we     : we_q;
    assign a_f3    = idle ? bus.req_funct3 : f3_q;
    assign a_addr  = idle ? bus.req_addr   : addr_q;
    assign a_wdata = idle ? bus.req_wdata  : wdata_q;

    assign idx       = a_addr[ADDR_W-1:OFF_W];
    assign off       = a_addr[OFF_W-1:0];
    assign do_access = (accept && legal && (WAIT_CYCLES == 0)) ||
                       ((state == S_WAIT) && (cnt == 4'd0));

    // Decode funct3 legality and natural alignment of the incoming request.
    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~bus.req_addr[0];
            3'b010:  legal = (bus.req_addr[1:0] == 2'b00);
            3'b011:  legal = (DATA_W == 64) && (bus.req_addr[2:0] == 3'b000);
            3'b100:  legal = ~bus.req_we;
            3'b101:  legal = ~bus.req_we && ~bus.req_addr[0];
            3'b110:  legal = (DATA_W == 64) && ~bus.req_we && (bus.req_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Shift the addressed bytes down to bit 0 and extend to the full data width.
    always_comb begin
        rd_sh = mem[idx] >> {off, 3'b000};
        b8    = rd_sh[7:0];
        h16   = rd_sh[15:0];
        w32   = rd_sh[31:0];
        case (a_f3)
            3'b000:  load_res = DATA_W'(b8);
            3'b001:  load_res = DATA_W'(h16);
            3'b010:  load_res = DATA_W'(w32);
            3'b100:  load_res = DATA_W'(rd_sh[7:0]);
            3'b101:  load_res = DATA_W'(rd_sh[15:0]);
            3'b110:  load_res = DATA_W'(rd_sh[31:0]);
            default: load_res = rd_sh;
        endcase
    end

    // Build byte enables and lane-aligned store data from access size and offset.
    always_comb begin
        case (a_f3[1:0])
            2'b00:   size_be = NB'(1);
            2'b01:   size_be = NB'(3);
            2'b10:   size_be = NB'(15);
            default: size_be = NB'(255);
        endcase
        be    = size_be << off;
        wd_sh = a_wdata << {off, 3'b000};
    end

    // Memory array is never reset; only committed stores touch it.
    always_ff @(posedge clk) begin
        if (do_access && a_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd_sh[8*i +: 8];
            end
        end
    end

    // Control FSM: accept, count wait states, commit, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (!legal) begin
                            state   <= S_RESP;
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state   <= S_RESP;
                            rdata_q <= bus.req_we ? '0 : load_res;
                            err_q   <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= S_RESP;
                        rdata_q <= we_q ? '0 : load_res;
                        err_q   <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait states, one with three.
// Latency: measured per transaction in edges after the accepting edge.
// Backpressure: holds rsp_ready low to check response stability.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n;
    logic        rst3_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    int checks = 0;
    int errors = 0;

    dmem_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b0 ();
    dmem_ctrl_if #(.ADDR_W(9), .DATA_W(32)) b3 ();

    dmem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst_n(rst0_n), .bus(b0));
    dmem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst_n(rst3_n), .bus(b3));

    assign b0.req_valid  = req_valid & ~sel;
    assign b3.req_valid  = req_valid & sel;
    assign b0.rsp_ready  = rsp_ready & ~sel;
    assign b3.rsp_ready  = rsp_ready & sel;
    assign b0.req_we     = req_we;
    assign b3.req_we     = req_we;
    assign b0.req_funct3 = req_f3;
    assign b3.req_funct3 = req_f3;
    assign b0.req_addr   = req_addr;
    assign b3.req_addr   = req_addr;
    assign b0.req_wdata  = req_wdata;
    assign b3.req_wdata  = req_wdata;

    logic        cur_valid;
    logic        cur_ready;
    logic [31:0] cur_rdata;
    logic        cur_err;
    assign cur_valid = sel ? b3.rsp_valid : b0.rsp_valid;
    assign cur_ready = sel ? b3.req_ready : b0.req_ready;
    assign cur_rdata = sel ? b3.rsp_rdata : b0.rsp_rdata;
    assign cur_err   = sel ? b3.rsp_err   : b0.rsp_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                           input logic [31:0] wd);
        req_we    = we;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // lat = edges after the accepting edge until rsp_valid is seen (WAIT_CYCLES for a legal access).
    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 0;
        while (!cur_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " vld_drop"}, 64'(cur_valid), 64'd0);
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [8:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        check({tag, " ready"}, 64'(cur_ready), 64'd1);
        put_req(we, f3, addr, wd);
        wait_rsp(tag, exp_lat);
        check({tag, " rdata"}, 64'(cur_rdata), 64'(exp_d));
        check({tag, " err"}, 64'(cur_err), 64'(exp_e));
        handshake(tag);
    endtask

    initial begin
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_f3    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        rst0_n    = 1'b0;
        rst3_n    = 1'b0;
        #12;
        check("rst vld0", 64'(b0.rsp_valid), 64'd0);
        check("rst err0", 64'(b0.rsp_err), 64'd0);
        check("rst rdata0", 64'(b0.rsp_rdata), 64'd0);
        check("rst vld3", 64'(b3.rsp_valid), 64'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst rdy0", 64'(b0.req_ready), 64'd1);
        check("rst rdy3", 64'(b3.req_ready), 64'd1);

        // No wait states
        xact("sw10",   1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        xact("lw10",   1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        xact("lb13",   1'b0, 3'b000, 9'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
        xact("lbu13",  1'b0, 3'b100, 9'h013, 32'h0,        32'h000000DE, 1'b0, 0);
        xact("lh12",   1'b0, 3'b001, 9'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 0);
        xact("lhu10",  1'b0, 3'b101, 9'h010, 32'h0,        32'h0000BEEF, 1'b0, 0);
        xact("lb10",   1'b0, 3'b000, 9'h010, 32'h0,        32'hFFFFFFEF, 1'b0, 0);
        xact("sb11",   1'b1, 3'b000, 9'h011, 32'h00000055, 32'h0,        1'b0, 0);
        xact("lw10b",  1'b0, 3'b010, 9'h010, 32'h0,        32'hDEAD55EF, 1'b0, 0);
        xact("lw12",   1'b0, 3'b010, 9'h012, 32'h0,        32'h0,        1'b1, 0);
        xact("lw10c",  1'b0, 3'b010, 9'h010, 32'h0,        32'hDEAD55EF, 1'b0, 0);
        xact("f3_111", 1'b0, 3'b111, 9'h010, 32'h0,        32'h0,        1'b1, 0);
        xact("lw10d",  1'b0, 3'b010, 9'h010, 32'h0,        32'hDEAD55EF, 1'b0, 0);
        xact("lh11",   1'b0, 3'b001, 9'h011, 32'h0,        32'h0,        1'b1, 0);
        xact("sh11",   1'b1, 3'b001, 9'h011, 32'h0000AAAA, 32'h0,        1'b1, 0);
        xact("sd10",   1'b1, 3'b011, 9'h010, 32'h11111111, 32'h0,        1'b1, 0);
        xact("sh12",   1'b1, 3'b001, 9'h012, 32'hFFFF1234, 32'h0,        1'b0, 0);
        xact("lw10e",  1'b0, 3'b010, 9'h010, 32'h0,        32'h123455EF, 1'b0, 0);

        // Three wait states
        sel = 1'b1;
        xact("w_sw20",  1'b1, 3'b010, 9'h020, 32'hCAFEF00D, 32'h0,        1'b0, 3);
        xact("w_lw20",  1'b0, 3'b010, 9'h020, 32'h0,        32'hCAFEF00D, 1'b0, 3);
        xact("w_lhu22", 1'b0, 3'b101, 9'h022, 32'h0,        32'h0000CAFE, 1'b0, 3);
        xact("w_lw21",  1'b0, 3'b010, 9'h021, 32'h0,        32'h0,        1'b1, 0);

        // Response held with rsp_ready low while a competing store is offered
        put_req(1'b0, 3'b010, 9'h020, 32'h0);
        wait_rsp("w_hold", 3);
        req_we    = 1'b1;
        req_addr  = 9'h020;
        req_wdata = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("w_hold vld", 64'(cur_valid), 64'd1);
            check("w_hold rdata", 64'(cur_rdata), 64'hCAFEF00D);
            check("w_hold rdy", 64'(cur_ready), 64'd0);
        end
        req_valid = 1'b0;
        handshake("w_hold");
        xact("w_lw20b", 1'b0, 3'b010, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0, 3);

        // Reset in WAIT abandons a store
        put_req(1'b1, 3'b010, 9'h020, 32'h12345678);
        @(posedge clk);
        #2;
        rst3_n = 1'b0;
        #1;
        check("w_rst vld", 64'(b3.rsp_valid), 64'd0);
        check("w_rst rdata", 64'(b3.rsp_rdata), 64'd0);
        check("w_rst err", 64'(b3.rsp_err), 64'd0);
        check("w_rst rdy", 64'(b3.req_ready), 64'd1);
        rst3_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("w_rst late", 64'(b3.rsp_valid), 64'd0);
        xact("w_lw20c", 1'b0, 3'b010, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
